// File: rtl/game_flow_ctrl.sv
// Tic-tac-toe game-flow sequencer: decodes mouse clicks against on-screen regions
// and steps title -> settle -> choice -> settle -> play -> game-over.
module game_flow_ctrl #(
  parameter int WAIT_CYCLES  = 75000000,
  parameter int N_CHOICES    = 2,
  parameter int START_X0     = 490,
  parameter int START_X1     = 530,
  parameter int START_Y0     = 600,
  parameter int START_Y1     = 615,
  parameter int CHOICE_X0    = 300,
  parameter int CHOICE_W     = 100,
  parameter int CHOICE_PITCH = 350,
  parameter int CHOICE_Y0    = 450,
  parameter int CHOICE_Y1    = 550,
  parameter logic [12*N_CHOICES-1:0] CHOICE_COLORS = {12'hff0, 12'h00f},
  localparam int IW = (N_CHOICES > 1) ? $clog2(N_CHOICES) : 1
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic [11:0]   mouse_xpos,
  input  logic [11:0]   mouse_ypos,
  input  logic          mouse_left,
  input  logic          game_over,
  output logic          start_en,
  output logic          choice_en,
  output logic          play_en,
  output logic          over_en,
  output logic [11:0]   square_color,
  output logic [IW-1:0] player_idx
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT1  = 3'd1,
    CHOICE = 3'd2,
    WAIT2  = 3'd3,
    PLAY   = 3'd4,
    OVER   = 3'd5
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] count, count_nx;
  logic          mouse_left_q;
  logic          click;
  logic [31:0]   mx, my, left_edge;
  logic          in_start;
  logic          choice_hit;
  logic [IW-1:0] hit_idx;
  logic [11:0]   hit_color;
  logic [11:0]   color_nx;
  logic [IW-1:0] idx_nx;
  logic          start_nx, choice_nx, play_nx, over_nx;

  assign click = mouse_left & ~mouse_left_q;
  assign mx    = {20'd0, mouse_xpos};
  assign my    = {20'd0, mouse_ypos};

  assign in_start = (mx >= 32'(START_X0)) && (mx <= 32'(START_X1)) &&
                    (my >= 32'(START_Y0)) && (my <= 32'(START_Y1));

  // Scan from the highest square down so the lowest overlapping index wins.
  always_comb begin
    choice_hit = 1'b0;
    hit_idx    = '0;
    hit_color  = 12'h000;
    left_edge  = '0;
    for (int i = N_CHOICES - 1; i >= 0; i--) begin
      left_edge = 32'(CHOICE_X0 + i * CHOICE_PITCH);
      if ((mx >= left_edge) && (mx <= left_edge + 32'(CHOICE_W)) &&
          (my >= 32'(CHOICE_Y0)) && (my <= 32'(CHOICE_Y1))) begin
        choice_hit = 1'b1;
        hit_idx    = IW'(i);
        hit_color  = CHOICE_COLORS[12*i +: 12];
      end
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    color_nx = square_color;
    idx_nx   = player_idx;
    case (state)
      IDLE: begin
        if (click && in_start) begin
          state_nx = WAIT1;
          count_nx = '0;
        end
      end
      WAIT1: begin
        if (count == WAIT_MAX) begin
          state_nx = CHOICE;
          count_nx = '0;
        end else begin
          count_nx = count + CW'(1);
        end
      end
      CHOICE: begin
        if (click && choice_hit) begin
          state_nx = WAIT2;
          color_nx = hit_color;
          idx_nx   = hit_idx;
        end
      end
      WAIT2: begin
        if (count == WAIT_MAX) begin
          state_nx = PLAY;
          count_nx = '0;
        end else begin
          count_nx = count + CW'(1);
        end
      end
      PLAY: begin
        if (game_over) begin
          state_nx = OVER;
          count_nx = '0;
        end
      end
      OVER: begin
        // Restart is locked out until the settle counter saturates.
        if (count == WAIT_MAX) begin
          if (click) begin
            state_nx = IDLE;
            count_nx = '0;
            color_nx = 12'h000;
            idx_nx   = '0;
          end
        end else begin
          count_nx = count + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        count_nx = '0;
        color_nx = 12'h000;
        idx_nx   = '0;
      end
    endcase
  end

  always_comb begin
    start_nx  = 1'b0;
    choice_nx = 1'b0;
    play_nx   = 1'b0;
    over_nx   = 1'b0;
    case (state_nx)
      CHOICE, WAIT2: begin
        start_nx  = 1'b1;
        choice_nx = 1'b1;
      end
      PLAY: begin
        start_nx = 1'b1;
        play_nx  = 1'b1;
      end
      OVER: begin
        start_nx = 1'b1;
        over_nx  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      mouse_left_q <= 1'b0;
      square_color <= 12'h000;
      player_idx   <= '0;
      start_en     <= 1'b0;
      choice_en    <= 1'b0;
      play_en      <= 1'b0;
      over_en      <= 1'b0;
    end else begin
      state        <= state_nx;
      count        <= count_nx;
      mouse_left_q <= mouse_left;
      square_color <= color_nx;
      player_idx   <= idx_nx;
      start_en     <= start_nx;
      choice_en    <= choice_nx;
      play_en      <= play_nx;
      over_en      <= over_nx;
    end
  end

endmodule
